load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes the ALU-computed effective address for LOAD and STORE instructions and runs one request/ready transaction per instruction against the data memory port.
- On a store it generates byte lanes and write data. On a load it selects, aligns and sign- or zero-extends the returned word.
- Holds the core stalled (`busy`) until the access completes or faults.

Parameters:
- `MEM_TIMEOUT`, 64: max cycles in REQ without `mem_ready` before a timeout fault. Must be >= 1.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin access. Sampled only in IDLE.
- `op_code` in 7: instruction opcode. LOAD = 7'b0000011, STORE = 7'b0100011.
- `funct3` in 3: access width and signedness.
- `alu_result` in 32: effective address (rs1 + imm) from the ALU.
- `store_data` in 32: rs2 value.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address, {addr[31:2], 2'b00}.
- `mem_wmask` out 4: byte write enables. Bit i corresponds to byte [8i+7:8i].
- `mem_wdata` out 32: lane-replicated write data.
- `mem_ready` in 1: memory completes the transfer in the cycle it is high while `mem_req` is high.
- `mem_rdata` in 32: read word. Valid in the cycle `mem_ready` is high.
- `busy` out 1: high in REQ and DONE.
- `done` out 1: one-cycle completion pulse.
- `load_value` out 32: extended load result. Held until the next `done`.
- `fault` out 2: 0 none, 1 misaligned, 2 illegal funct3, 3 timeout. Valid with `done`, held until the next `done`.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - `mem_req`, `mem_we`, `mem_wmask`, `busy`, `done` = 0.
  - `mem_addr`, `mem_wdata`, `load_value` = 0.
  - `fault` = 0. Timeout counter = 0.
  - Reset mid-transaction abandons the access. `mem_req` is low on the cycle after the reset edge and no `done` is produced.
- States: IDLE, REQ, DONE.
- IDLE with `start` = 1:
  - Latch address, `funct3`, store data and `op_code` into registers. Outputs are driven from these registers only; inputs may change after the `start` cycle.
  - Valid access: go to REQ.
  - Misaligned, illegal funct3, or non-LOAD/STORE opcode: go straight to DONE with no memory access.
  - Non-LOAD/STORE opcode: `fault` = 0, `load_value` = 0.
- Legal funct3:
  - LOAD: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - STORE: 0 SB, 1 SH, 2 SW.
  - Anything else gives `fault` = 2.
- Misalignment (`fault` = 1):
  - Half-word access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Illegal funct3 takes priority over misalignment.
- REQ:
  - `mem_req` = 1. Address, `mem_we`, mask and data are held stable.
  - `mem_ready` = 1: capture read data (loads), go to DONE.
  - Otherwise the counter increments. When it reaches `MEM_TIMEOUT` with no `mem_ready`, drop `mem_req` and go to DONE with `fault` = 3 and `load_value` unchanged.
  - If `mem_ready` is high in the same cycle the counter reaches `MEM_TIMEOUT`, the cycle is a success.
- DONE: `done` = 1 for exactly one cycle, `mem_req` = 0, then go to IDLE. `start` in DONE is ignored.
- Latency:
  - With `start` at cycle t and `mem_ready` tied high: REQ at t+1, `done` at t+2.
  - Fault path: `done` at t+1.
- Back-to-back: the next `start` is accepted in the IDLE cycle after DONE. Minimum spacing is 3 cycles.
- Store lanes, with `o` = addr[1:0]:
  - SB: `mem_wdata` = {4{sd[7:0]}}, `mem_wmask` = 1 << o.
  - SH: `mem_wdata` = {2{sd[15:0]}}, `mem_wmask` = o[1] ? 4'b1100 : 4'b0011.
  - SW: `mem_wdata` = sd, `mem_wmask` = 4'b1111.
  - `mem_we` = 1 for stores, 0 for loads.
  - `mem_wmask` = 0 for loads.
- Load extract, with `o` = addr[1:0]:
  - Byte = rdata[8*o +: 8].
  - Half = rdata[16*o[1] +: 16].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW is passed through.
- `start` while busy is ignored, with no queueing.

Decomposition:
- Shared package `riscv_pkg`:
  - Opcode enum, moved out of the ALU so both blocks import it.
  - funct3 load/store width constants.
  - Fault code enum.
  - LSU state enum.
- One combinational sub-module, `lsu_load_align`: inputs rdata, offset[1:0], funct3; output 32-bit extended value. It is unit-testable on its own.

Test Plan:
- SW addr 0x1000, sd 0xDEADBEEF, `mem_ready` tied 1 -> `mem_req` at t+1 with `mem_addr` 0x1000, wmask 4'b1111, wdata 0xDEADBEEF; `done` at t+2, `fault` 0.
- SB addr 0x1003, sd 0x000000A5 -> wmask 4'b1000, wdata 0xA5A5A5A5. SH addr 0x1002, sd 0x1234 -> wmask 4'b1100, wdata 0x12341234.
- LB addr 0x2001, rdata 0x00008000 -> `load_value` 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x2002, rdata 0x80010000 -> 0xFFFF8001.
- LW addr 0x2002 -> `done` at t+1, `fault` 1, `mem_req` never asserted. Load with funct3 3 -> `fault` 2.
- `mem_ready` held 0, `MEM_TIMEOUT` 4 -> `mem_req` high for exactly 4 cycles then low; `done` with `fault` 3. Rerun with ready in the 4th cycle -> `fault` 0.
- `reset` asserted during REQ after 2 wait cycles -> next cycle `mem_req` 0, state IDLE, no `done`. `start` asserted while busy -> no second transaction issued.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execute and memory stages: opcodes, access
// widths, LSU fault codes and LSU states, plus the access legality checks.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_REG      = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_ILLEGAL  = 2'd2,
        FAULT_TIMEOUT  = 2'd3
    } fault_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Stores only have signed-width encodings; loads add the unsigned variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word from a memory read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_value_c
);
    import riscv_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_value_c = rdata;
        case (funct3)
            F3_B:    ext_value_c = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ext_value_c = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ext_value_c = {24'd0, byte_sel};
            F3_HU:   ext_value_c = {16'd0, half_sel};
            default: ext_value_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/ready data-memory transaction per LOAD/STORE,
// with store lane generation, load extraction and fault reporting.
module load_store_unit #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  op_code,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_value,
    output logic [1:0]  fault
);
    import riscv_pkg::*;

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        offset_q, offset_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       load_value_q, load_value_d;
    logic [1:0]        fault_q, fault_d;

    logic              in_is_load, in_is_store;
    logic [3:0]        st_wmask;
    logic [31:0]       st_wdata;
    logic [31:0]       aligned_c;

    assign in_is_load  = (op_code == OP_LOAD);
    assign in_is_store = (op_code == OP_STORE);

    // Store byte lanes from the incoming address; only legal widths reach REQ.
    always_comb begin
        st_wmask = 4'b1111;
        st_wdata = store_data;
        case (funct3)
            F3_B: begin
                st_wmask = 4'(4'b0001 << alu_result[1:0]);
                st_wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                st_wmask = alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_align (
        .rdata       (mem_rdata),
        .offset      (offset_q),
        .funct3      (funct3_q),
        .ext_value_c (aligned_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_value_d = load_value_q;
        fault_d      = fault_q;

        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    is_load_d  = in_is_load;
                    funct3_d   = funct3;
                    offset_d   = alu_result[1:0];
                    mem_addr_d = {alu_result[31:2], 2'b00};
                    busy_d     = 1'b1;
                    if (!in_is_load && !in_is_store) begin
                        state_d      = LSU_DONE;
                        done_d       = 1'b1;
                        fault_d      = FAULT_NONE;
                        load_value_d = 32'd0;
                    end else if (!f3_legal(in_is_store, funct3)) begin
                        state_d = LSU_DONE;
                        done_d  = 1'b1;
                        fault_d = FAULT_ILLEGAL;
                    end else if (misaligned(funct3, alu_result[1:0])) begin
                        state_d = LSU_DONE;
                        done_d  = 1'b1;
                        fault_d = FAULT_MISALIGN;
                    end else begin
                        state_d     = LSU_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_is_store;
                        mem_wmask_d = in_is_store ? st_wmask : 4'b0000;
                        mem_wdata_d = in_is_store ? st_wdata : 32'd0;
                    end
                end
            end
            LSU_REQ: begin
                // A ready in the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    state_d     = LSU_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wmask_d = 4'b0000;
                    done_d      = 1'b1;
                    fault_d     = FAULT_NONE;
                    if (is_load_q) begin
                        load_value_d = aligned_c;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = LSU_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wmask_d = 4'b0000;
                    done_d      = 1'b1;
                    fault_d     = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = LSU_IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'd0;
            offset_q     <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wmask_q  <= 4'd0;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_value_q <= 32'd0;
            fault_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_value_q <= load_value_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_value = load_value_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// transactions compared against a behavioural access model.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] load_value;
    logic [1:0]  fault;

    load_store_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .op_code(op_code), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .load_value(load_value), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by issue()
    int          o_lat, o_req;
    logic        o_stable, o_busy_ok, o_tail_ok, o_we;
    logic [1:0]  o_fault;
    logic [31:0] o_lv, o_addr, o_wdata;
    logic [3:0]  o_wmask;

    logic [31:0] model_lv;

    // Expected outcome of one access from the architectural rules.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sd,
                                  input logic [31:0] rd, input int delay,
                                  inout logic [31:0] lv, output logic [1:0] e_fault,
                                  output logic e_acc, output logic [3:0] e_wmask,
                                  output logic [31:0] e_wdata, output int e_req,
                                  output int e_lat);
        bit is_ld, is_st, legal;
        int nbytes, o;
        longint v, m;
        is_ld  = (op == LOAD);
        is_st  = (op == STORE);
        nbytes = 1 << f3[1:0];
        o      = int'(addr[1:0]);
        legal  = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        e_fault = 2'd0; e_acc = 1'b0; e_wmask = 4'd0; e_wdata = 32'd0; e_req = 0; e_lat = 1;
        if (!is_ld && !is_st) begin
            lv = 32'd0;
        end else if (!legal) begin
            e_fault = 2'd2;
        end else if ((o % nbytes) != 0) begin
            e_fault = 2'd1;
        end else begin
            e_acc = 1'b1;
            if (is_st) begin
                e_wmask = 4'(((1 << nbytes) - 1) << o);
                for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = sd[8*(i % nbytes) +: 8];
            end
            if (delay >= int'(TMO)) begin
                e_fault = 2'd3; e_req = TMO; e_lat = TMO + 1;
            end else begin
                e_req = delay + 1; e_lat = delay + 2;
                if (is_ld) begin
                    m = (64'd1 << (8 * nbytes)) - 1;
                    v = ({32'd0, rd} >> (8 * o)) & m;
                    if (!f3[2] && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1) v = v | ~m;
                    lv = v[31:0];
                end
            end
        end
    endfunction

    // Drive one start and act as memory: ready on request cycle delay+1.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rd, input int delay,
                         input bit poke);
        o_lat = 0; o_req = 0; o_stable = 1'b1; o_busy_ok = 1'b1; o_tail_ok = 1'b1;
        o_we = 1'b0; o_fault = 2'd0; o_lv = 32'd0; o_addr = 32'd0; o_wdata = 32'd0; o_wmask = 4'd0;
        @(negedge clk);
        start = 1'b1; op_code = op; funct3 = f3; alu_result = addr; store_data = sd;
        mem_ready = 1'b0; mem_rdata = $urandom;
        for (int c = 1; c <= int'(TMO) + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = poke; op_code = poke ? LOAD : 7'($urandom); funct3 = 3'($urandom);
                alu_result = $urandom & 32'hFFFF_FFFC; store_data = $urandom;
            end
            if (busy !== 1'b1) o_busy_ok = 1'b0;
            if (done === 1'b1) begin
                o_lat = c; o_fault = fault; o_lv = load_value; mem_ready = 1'b0;
                break;
            end
            if (mem_req === 1'b1) begin
                if (o_req == 0) begin
                    o_addr = mem_addr; o_we = mem_we; o_wmask = mem_wmask; o_wdata = mem_wdata;
                end else if (mem_addr !== o_addr || mem_we !== o_we || mem_wmask !== o_wmask ||
                             mem_wdata !== o_wdata) begin
                    o_stable = 1'b0;
                end
                o_req++;
                mem_ready = (o_req == delay + 1);
                mem_rdata = mem_ready ? rd : $urandom;
            end else begin
                mem_ready = 1'b0;
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) o_tail_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
        op_code = 7'd0; funct3 = 3'd0; alu_result = 32'd0; store_data = 32'd0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_wmask, busy, done} !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 0", {mem_req, mem_we, mem_wmask, busy, done});
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            n_fail++; $display("FAIL reset_bus got %h/%h want 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if ({load_value, fault} !== 34'd0) begin
            n_fail++; $display("FAIL reset_result got %h/%0d want 0/0", load_value, fault);
        end
        reset = 1'b0;
        model_lv = 32'd0;
    endtask

    task automatic test_store_lanes();
        logic [6:0]  ops [3]  = '{STORE, STORE, STORE};
        logic [2:0]  f3s [3]  = '{3'd2, 3'd0, 3'd1};
        logic [31:0] adr [3]  = '{32'h1000, 32'h1003, 32'h1002};
        logic [31:0] sds [3]  = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
        logic [3:0]  wm  [3]  = '{4'b1111, 4'b1000, 4'b1100};
        logic [31:0] wd  [3]  = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], f3s[i], adr[i], sds[i], 32'h0, 0, 1'b0);
            n_checks++;
            if (o_req !== 1 || o_lat !== 2 || o_fault !== 2'd0) begin
                n_fail++; $display("FAIL store%0d_timing req %0d lat %0d fault %0d want 1/2/0", i, o_req, o_lat, o_fault);
            end
            n_checks++;
            if (o_addr !== (adr[i] & 32'hFFFF_FFFC) || o_we !== 1'b1) begin
                n_fail++; $display("FAIL store%0d_addr got %h we %b want %h we 1", i, o_addr, o_we, adr[i] & 32'hFFFF_FFFC);
            end
            n_checks++;
            if (o_wmask !== wm[i] || o_wdata !== wd[i]) begin
                n_fail++; $display("FAIL store%0d_lanes got %b/%h want %b/%h", i, o_wmask, o_wdata, wm[i], wd[i]);
            end
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd1};
        logic [31:0] adr [3] = '{32'h2001, 32'h2001, 32'h2002};
        logic [31:0] rds [3] = '{32'h00008000, 32'h00008000, 32'h80010000};
        logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
        for (int i = 0; i < 3; i++) begin
            issue(LOAD, f3s[i], adr[i], 32'h0, rds[i], 1, 1'b0);
            n_checks++;
            if (o_lv !== exp[i] || o_fault !== 2'd0) begin
                n_fail++; $display("FAIL load%0d_value got %h fault %0d want %h fault 0", i, o_lv, o_fault, exp[i]);
            end
            n_checks++;
            if (o_we !== 1'b0 || o_wmask !== 4'd0 || o_lat !== 3) begin
                n_fail++; $display("FAIL load%0d_ctrl we %b wmask %b lat %0d want 0/0/3", i, o_we, o_wmask, o_lat);
            end
            model_lv = exp[i];
        end
    endtask

    task automatic test_faults();
        issue(LOAD, 3'd2, 32'h2002, 32'h0, 32'h0, 0, 1'b0);
        n_checks++;
        if (o_fault !== 2'd1 || o_lat !== 1 || o_req !== 0) begin
            n_fail++; $display("FAIL misalign fault %0d lat %0d req %0d want 1/1/0", o_fault, o_lat, o_req);
        end
        issue(LOAD, 3'd3, 32'h2000, 32'h0, 32'h0, 0, 1'b0);
        n_checks++;
        if (o_fault !== 2'd2 || o_lat !== 1 || o_req !== 0) begin
            n_fail++; $display("FAIL illegal_f3 fault %0d lat %0d req %0d want 2/1/0", o_fault, o_lat, o_req);
        end
        issue(STORE, 3'd6, 32'h2001, 32'h0, 32'h0, 0, 1'b0);
        n_checks++;
        if (o_fault !== 2'd2) begin
            n_fail++; $display("FAIL illegal_prio fault %0d want 2", o_fault);
        end
        issue(7'b0110011, 3'd0, 32'h2000, 32'h0, 32'h0, 0, 1'b0);
        n_checks++;
        if (o_fault !== 2'd0 || o_lv !== 32'd0 || o_lat !== 1 || o_req !== 0) begin
            n_fail++; $display("FAIL non_mem fault %0d lv %h lat %0d req %0d want 0/0/1/0", o_fault, o_lv, o_lat, o_req);
        end
        model_lv = 32'd0;
    endtask

    task automatic test_timeout();
        issue(LOAD, 3'd2, 32'h3000, 32'h0, 32'h11112222, 0, 1'b0);
        model_lv = 32'h11112222;
        issue(LOAD, 3'd2, 32'h3004, 32'h0, 32'h0, int'(TMO) + 5, 1'b0);
        n_checks++;
        if (o_req !== int'(TMO) || o_fault !== 2'd3 || o_lat !== int'(TMO) + 1) begin
            n_fail++; $display("FAIL timeout req %0d fault %0d lat %0d want %0d/3/%0d", o_req, o_fault, o_lat, TMO, TMO + 1);
        end
        n_checks++;
        if (o_lv !== model_lv || o_tail_ok !== 1'b1) begin
            n_fail++; $display("FAIL timeout_hold lv %h tail %b want %h/1", o_lv, o_tail_ok, model_lv);
        end
        issue(LOAD, 3'd2, 32'h3008, 32'h0, 32'h5A5A0F0F, int'(TMO) - 1, 1'b0);
        n_checks++;
        if (o_req !== int'(TMO) || o_fault !== 2'd0 || o_lv !== 32'h5A5A0F0F) begin
            n_fail++; $display("FAIL last_ready req %0d fault %0d lv %h want %0d/0/5a5a0f0f", o_req, o_fault, o_lv, TMO);
        end
        model_lv = 32'h5A5A0F0F;
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        @(negedge clk);
        start = 1'b1; op_code = LOAD; funct3 = 3'd2; alu_result = 32'h4000; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre mem_req %b want 1", mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_post req %b busy %b done %b want 0/0/0", mem_req, busy, done);
        end
        mem_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || mem_req !== 1'b0) stray++;
        end
        mem_ready = 1'b0;
        n_checks++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL rst_mid_idle stray activity %0d want 0", stray);
        end
        model_lv = 32'd0;
    endtask

    task automatic test_start_while_busy();
        issue(LOAD, 3'd1, 32'h5002, 32'h0, 32'hBEEF0000, 2, 1'b1);
        n_checks++;
        if (o_stable !== 1'b1 || o_addr !== 32'h5000 || o_req !== 3) begin
            n_fail++; $display("FAIL busy_start stable %b addr %h req %0d want 1/5000/3", o_stable, o_addr, o_req);
        end
        n_checks++;
        if (o_tail_ok !== 1'b1 || o_lv !== 32'hFFFFBEEF) begin
            n_fail++; $display("FAIL busy_start_tail tail %b lv %h want 1/ffffbeef", o_tail_ok, o_lv);
        end
        model_lv = 32'hFFFFBEEF;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_extra busy %b req %b want 0/0", busy, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; op_code = STORE; funct3 = 3'd2; alu_result = 32'h6000;
        store_data = 32'h01020304; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_done got %b want 1", done);
        end
        start = 1'b1; op_code = LOAD; funct3 = 3'd2; alu_result = 32'h6004; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done_ignores busy %b req %b want 0/0", busy, mem_req);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h6004 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_req req %b addr %h we %b want 1/6004/0", mem_req, mem_addr, mem_we);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || load_value !== 32'hCAFEF00D || fault !== 2'd0) begin
            n_fail++; $display("FAIL b2b_second_done done %b lv %h fault %0d want 1/cafef00d/0", done, load_value, fault);
        end
        model_lv = 32'hCAFEF00D;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [6:0]  others [4] = '{7'h13, 7'h33, 7'h37, 7'h63};
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr, sd, rd, e_wdata;
        logic [1:0]  e_fault;
        logic        e_acc;
        logic [3:0]  e_wmask;
        int          r, delay, e_req, e_lat;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? LOAD : (r < 8) ? STORE : others[$urandom_range(0, 3)];
            f3 = 3'($urandom); addr = $urandom; sd = $urandom; rd = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            delay = $urandom_range(0, TMO + 1);
            model(op, f3, addr, sd, rd, delay, model_lv, e_fault, e_acc, e_wmask, e_wdata, e_req, e_lat);
            issue(op, f3, addr, sd, rd, delay, 1'b0);
            n_checks++;
            if (o_fault !== e_fault || o_lat !== e_lat || o_req !== e_req) begin
                n_fail++; $display("FAIL rand%0d_flow fault %0d lat %0d req %0d want %0d/%0d/%0d",
                                   k, o_fault, o_lat, o_req, e_fault, e_lat, e_req);
            end
            n_checks++;
            if (o_lv !== model_lv) begin
                n_fail++; $display("FAIL rand%0d_load_value got %h want %h", k, o_lv, model_lv);
            end
            n_checks++;
            if ({o_stable, o_busy_ok, o_tail_ok} !== 3'b111) begin
                n_fail++; $display("FAIL rand%0d_handshake stable/busy/tail %b want 111", k, {o_stable, o_busy_ok, o_tail_ok});
            end
            if (e_acc) begin
                n_checks++;
                if (o_addr !== {addr[31:2], 2'b00} || o_we !== (op == STORE) ||
                    o_wmask !== e_wmask || (op == STORE && o_wdata !== e_wdata)) begin
                    n_fail++; $display("FAIL rand%0d_bus addr %h we %b wmask %b wdata %h want %h/%b/%b/%h",
                                       k, o_addr, o_we, o_wmask, o_wdata, {addr[31:2], 2'b00}, op == STORE, e_wmask, e_wdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_load_extend();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
